lot_sensor_decoder: RTL and testbench
=====================================

# lot_sensor_decoder

Decodes the two raw photo-sensor inputs at the parking-lot gate into clean single-cycle `enter` and `exit` pulses. These pulses drive the occupancy counter directly downstream. The block synchronizes the asynchronous sensor lines, tracks the full four-phase car-crossing sequence in an FSM, and rejects pedestrians, reversals and glitches. It also times out stalled crossings and reports them on `fault`.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages per sensor synchronizer; must be ≥ 2.
- `TIMEOUT_CYCLES`, default 1000: maximum dwell in one crossing state before abort; must be ≥ 2. The timer width is $clog2(TIMEOUT_CYCLES).
- `clk`  in  1  single system clock; all state is updated on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `a`  in  1  outer sensor, raw and asynchronous; 1 = beam blocked.
- `b`  in  1  inner sensor, raw and asynchronous; 1 = beam blocked.
- `enter`  out  1  one-cycle pulse per completed entry.
- `exit`  out  1  one-cycle pulse per completed exit.
- `fault`  out  1  one-cycle pulse on an illegal pattern step or a timeout.
- `busy`  out  1  high whenever the state is not IDLE; registered from the state.

## Operation
- Pattern p = {a_s, b_s}, where a_s and b_s are the synchronized copies of `a` and `b`.
- FSM states: IDLE, EN_A, EN_AB, EN_B, EX_B, EX_AB, EX_A, WAIT_CLR.
- IDLE:
  - p=10 → EN_A.
  - p=01 → EX_B.
  - p=11 → WAIT_CLR, with `fault`.
  - p=00 → stay.
- EN_A:
  - p=11 → EN_AB.
  - p=00 → IDLE, no pulse (pedestrian or back-out).
  - p=01 → WAIT_CLR, with `fault`.
  - p=10 → stay.
- EN_AB:
  - p=01 → EN_B.
  - p=10 → EN_A (reversal).
  - p=00 → WAIT_CLR, with `fault`.
  - p=11 → stay.
- EN_B:
  - p=00 → IDLE, with `enter`.
  - p=11 → EN_AB.
  - p=10 → WAIT_CLR, with `fault`.
  - p=01 → stay.
- EX_B, EX_AB, EX_A mirror the entry states with a and b swapped. EX_A with p=00 → IDLE, with `exit`.
- WAIT_CLR: p=00 → IDLE; any other pattern → stay. No further `fault` pulses are issued from this state.
- Dwell timer:
  - Cleared on every state change and whenever the state is IDLE or WAIT_CLR.
  - Otherwise increments once per cycle.
  - When it equals TIMEOUT_CYCLES-1 with no transition that cycle, the FSM goes to WAIT_CLR and pulses `fault`.
  - Timeout takes priority only when the pattern is unchanged. A legal transition on the same cycle wins.
- `enter`, `exit` and `fault` are mutually exclusive by construction. Each is high for exactly one cycle per event.

## Timing
- Reset (asynchronous, active-high):
  - All synchronizer flops clear to 0, so p=00.
  - State = IDLE, timer = 0.
  - `enter`, `exit`, `fault`, `busy` = 0, effective immediately on assertion.
- Reset asserted mid-crossing abandons the crossing with no pulse. After release, the FSM starts in IDLE and rebuilds its view from the live pattern.
- Latency: a raw pattern stable before rising edge k becomes p after SYNC_STAGES edges.
- The FSM acts on that p at the next edge. Outputs are registered at that edge, so a pulse is visible SYNC_STAGES+1 edges after the raw change (3 cycles with the defaults).
- `busy` changes on the same edge as the state register.
- Raw sensor changes shorter than one clock period may be missed. This is allowed.
- Back-to-back cars: an entry completing on edge n may be followed by a new crossing starting at edge n+1.

## Structure
- Package `parking_pkg`:
  - `sensor_state_e` enum typedef for the FSM states.
  - Localparams for the patterns P_NONE=2'b00, P_A=2'b10, P_B=2'b01, P_AB=2'b11.
- Sub-module `bit_sync`: a parameterized STAGES-deep flip-flop chain with asynchronous reset to 0, instantiated once for `a` and once for `b`.
- Top level contains the FSM (next-state always_comb plus state register), the dwell timer, and the registered output pulses.

## Test plan
- Entry: drive 00, 10, 11, 01, 00, each held 5 cycles → exactly one `enter` pulse, 3 cycles after the final 00 is applied; `exit`=`fault`=0; `busy` returns to 0.
- Exit: drive 00, 01, 11, 10, 00 → exactly one `exit` pulse. Then 30 entries followed by 30 exits → 30 `enter` and 30 `exit` pulses, never adjacent to each other.
- Rejection:
  - Pedestrian 10 → 00 → no pulses.
  - Reversal 10, 11, 10, 00 → no pulses.
  - Partial exit 01, 11, 01, 00 → no pulses.
- Illegal step: from IDLE drive 11 → one `fault` pulse and `busy`=1 while 11 is held. Return to 00 → `busy`=0. A following full entry still gives one `enter`.
- Timeout with TIMEOUT_CYCLES=8: hold 10 for 20 cycles → one `fault` on the 8th cycle in EN_A. Then drive 11, 01, 00 → no `enter` (WAIT_CLR holds until 00).
- Reset: assert `reset` asynchronously while in EN_AB → all outputs 0 before the next edge. Release, then drive 01, 00 → treated as a partial exit; no `enter`, no `exit`.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types for the parking-lot gate sensor decoder:
// FSM state encoding, sensor pattern codes and the output pulse bundle.
package parking_pkg;

   typedef enum logic [2:0] {
      IDLE,
      EN_A,
      EN_AB,
      EN_B,
      EX_B,
      EX_AB,
      EX_A,
      WAIT_CLR
   } sensor_state_e;

   localparam logic [1:0] P_NONE = 2'b00;
   localparam logic [1:0] P_A    = 2'b10;
   localparam logic [1:0] P_B    = 2'b01;
   localparam logic [1:0] P_AB   = 2'b11;

   typedef struct packed {
      logic enter;
      logic exit;
      logic fault;
   } pulse_t;

   // Only the six crossing states accumulate dwell time.
   function automatic logic dwell_timed(sensor_state_e s);
      return !(s inside {IDLE, WAIT_CLR});
   endfunction

endpackage

// File: rtl/lot_sensor_decoder_if.sv
// Sensor inputs and decoded event outputs of the gate decoder.
// The decoder sits on the slave side; the sensor/consumer side is master.
interface lot_sensor_decoder_if;

   logic a;
   logic b;
   logic enter;
   logic exit;
   logic fault;
   logic busy;

   modport master (
      output a, b,
      input  enter, exit, fault, busy
   );

   modport slave (
      input  a, b,
      output enter, exit, fault, busy
   );

endinterface

// File: rtl/bit_sync.sv
// STAGES-deep flip-flop synchronizer for one asynchronous input bit.
// Asynchronous reset clears the whole chain to 0.
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/lot_sensor_decoder.sv
// Turns the two gate photo-sensors into single-cycle enter/exit/fault
// pulses by tracking the four-phase crossing sequence with a dwell timeout.
module lot_sensor_decoder
   import parking_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                 clk,
   input  logic                 reset,
   lot_sensor_decoder_if.slave  sen
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic          a_s;
   logic          b_s;
   logic [1:0]    p;
   sensor_state_e state_q, state_d, step;
   logic [TW-1:0] timer_q, timer_d;
   pulse_t        pulse_q, pulse_d;
   logic          busy_q, busy_d;

   bit_sync #(.STAGES(SYNC_STAGES)) u_sync_a (
      .clk (clk),
      .rst (reset),
      .d   (sen.a),
      .q   (a_s)
   );

   bit_sync #(.STAGES(SYNC_STAGES)) u_sync_b (
      .clk (clk),
      .rst (reset),
      .d   (sen.b),
      .q   (b_s)
   );

   assign p = {a_s, b_s};

   always_comb begin
      step    = state_q;
      pulse_d = '0;
      unique case (state_q)
         IDLE: begin
            case (p)
               P_A:  step = EN_A;
               P_B:  step = EX_B;
               P_AB: begin step = WAIT_CLR; pulse_d.fault = 1'b1; end
               default: ;
            endcase
         end
         EN_A: begin
            case (p)
               P_AB:   step = EN_AB;
               P_NONE: step = IDLE;
               P_B:    begin step = WAIT_CLR; pulse_d.fault = 1'b1; end
               default: ;
            endcase
         end
         EN_AB: begin
            case (p)
               P_B:    step = EN_B;
               P_A:    step = EN_A;
               P_NONE: begin step = WAIT_CLR; pulse_d.fault = 1'b1; end
               default: ;
            endcase
         end
         EN_B: begin
            case (p)
               P_NONE: begin step = IDLE; pulse_d.enter = 1'b1; end
               P_AB:   step = EN_AB;
               P_A:    begin step = WAIT_CLR; pulse_d.fault = 1'b1; end
               default: ;
            endcase
         end
         EX_B: begin
            case (p)
               P_AB:   step = EX_AB;
               P_NONE: step = IDLE;
               P_A:    begin step = WAIT_CLR; pulse_d.fault = 1'b1; end
               default: ;
            endcase
         end
         EX_AB: begin
            case (p)
               P_A:    step = EX_A;
               P_B:    step = EX_B;
               P_NONE: begin step = WAIT_CLR; pulse_d.fault = 1'b1; end
               default: ;
            endcase
         end
         EX_A: begin
            case (p)
               P_NONE: begin step = IDLE; pulse_d.exit = 1'b1; end
               P_AB:   step = EX_AB;
               P_B:    begin step = WAIT_CLR; pulse_d.fault = 1'b1; end
               default: ;
            endcase
         end
         WAIT_CLR: begin
            if (p == P_NONE) step = IDLE;
         end
      endcase

      // A stalled crossing aborts only if the pattern did not move it on.
      state_d = step;
      if (step == state_q && dwell_timed(state_q) && timer_q == T_LAST) begin
         state_d       = WAIT_CLR;
         pulse_d.fault = 1'b1;
      end

      if (state_d != state_q || !dwell_timed(state_q)) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + TW'(1);
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         timer_q <= '0;
         pulse_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         pulse_q <= pulse_d;
         busy_q  <= busy_d;
      end
   end

   assign sen.enter = pulse_q.enter;
   assign sen.exit  = pulse_q.exit;
   assign sen.fault = pulse_q.fault;
   assign sen.busy  = busy_q;

endmodule

// File: tb/tb_lot_sensor_decoder.sv
// Directed bench for lot_sensor_decoder (SYNC_STAGES=2, TIMEOUT_CYCLES=8):
// crossings, rejections, illegal steps, timeout and mid-crossing reset.
module tb_lot_sensor_decoder;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   lot_sensor_decoder_if sen ();

   lot_sensor_decoder #(
      .SYNC_STAGES    (2),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .sen   (sen)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_en = 0, n_ex = 0, n_ft = 0;
   int en_cyc = 0, ex_cyc = 0, ft_cyc = 0;
   int adj = 0, wide = 0;
   int apply_cyc = 0;
   int e0, x0, f0, t;
   logic pe = 1'b0, px = 1'b0, pf = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (sen.enter === 1'b1) begin n_en++; en_cyc = cyc; end
      if (sen.exit === 1'b1) begin n_ex++; ex_cyc = cyc; end
      if (sen.fault === 1'b1) begin n_ft++; ft_cyc = cyc; end
      if ((sen.enter === 1'b1 && (px || sen.exit === 1'b1)) ||
          (sen.exit === 1'b1 && pe))
         adj++;
      if ((sen.enter === 1'b1 && pe) || (sen.exit === 1'b1 && px) ||
          (sen.fault === 1'b1 && pf))
         wide++;
      pe = (sen.enter === 1'b1);
      px = (sen.exit === 1'b1);
      pf = (sen.fault === 1'b1);
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] p, input int n);
      @(negedge clk);
      {sen.a, sen.b} = p;
      apply_cyc = cyc;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic base();
      e0 = n_en;
      x0 = n_ex;
      f0 = n_ft;
   endtask

   initial begin
      sen.a = 1'b0;
      sen.b = 1'b0;
      reset = 1'b0;
      #1 reset = 1'b1;
      #1;
      chk("rst_enter", sen.enter, 1'b0);
      chk("rst_exit", sen.exit, 1'b0);
      chk("rst_fault", sen.fault, 1'b0);
      chk("rst_busy", sen.busy, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // single entry
      base();
      drive(2'b00, 5); drive(2'b10, 5); drive(2'b11, 5);
      drive(2'b01, 5); drive(2'b00, 5);
      t = apply_cyc;
      drive(2'b00, 3);
      chk("entry_cnt", n_en - e0, 1);
      chk("entry_lat", en_cyc - t, 3);
      chk("entry_noexit", n_ex - x0, 0);
      chk("entry_nofault", n_ft - f0, 0);
      chk("entry_busy", sen.busy, 1'b0);

      // single exit
      base();
      drive(2'b01, 5); drive(2'b11, 5); drive(2'b10, 5); drive(2'b00, 5);
      t = apply_cyc;
      drive(2'b00, 3);
      chk("exit_cnt", n_ex - x0, 1);
      chk("exit_lat", ex_cyc - t, 3);
      chk("exit_noenter", n_en - e0, 0);
      chk("exit_nofault", n_ft - f0, 0);

      // 30 entries then 30 exits
      base();
      for (int i = 0; i < 30; i++) begin
         drive(2'b10, 3); drive(2'b11, 3); drive(2'b01, 3); drive(2'b00, 3);
      end
      for (int i = 0; i < 30; i++) begin
         drive(2'b01, 3); drive(2'b11, 3); drive(2'b10, 3); drive(2'b00, 3);
      end
      drive(2'b00, 4);
      chk("burst_enter", n_en - e0, 30);
      chk("burst_exit", n_ex - x0, 30);
      chk("burst_fault", n_ft - f0, 0);
      chk("burst_adjacent", adj, 0);
      chk("burst_width", wide, 0);

      // pedestrian, reversal, partial exit
      base();
      drive(2'b10, 5); drive(2'b00, 5);
      drive(2'b10, 5); drive(2'b11, 5); drive(2'b10, 5); drive(2'b00, 5);
      drive(2'b01, 5); drive(2'b11, 5); drive(2'b01, 5); drive(2'b00, 5);
      drive(2'b00, 3);
      chk("reject_enter", n_en - e0, 0);
      chk("reject_exit", n_ex - x0, 0);
      chk("reject_fault", n_ft - f0, 0);
      chk("reject_busy", sen.busy, 1'b0);

      // illegal 11 from IDLE
      base();
      drive(2'b11, 5);
      t = apply_cyc;
      chk("illegal_busy", sen.busy, 1'b1);
      chk("illegal_fault", n_ft - f0, 1);
      chk("illegal_lat", ft_cyc - t, 3);
      drive(2'b00, 5);
      chk("illegal_clr_busy", sen.busy, 1'b0);
      drive(2'b10, 5); drive(2'b11, 5); drive(2'b01, 5); drive(2'b00, 5);
      drive(2'b00, 3);
      chk("illegal_then_enter", n_en - e0, 1);
      chk("illegal_fault_once", n_ft - f0, 1);

      // dwell timeout in EN_A
      base();
      drive(2'b10, 20);
      t = apply_cyc;
      chk("tmo_fault", n_ft - f0, 1);
      chk("tmo_lat", ft_cyc - t, 11);
      chk("tmo_busy", sen.busy, 1'b1);
      drive(2'b11, 5); drive(2'b01, 5); drive(2'b00, 5);
      drive(2'b00, 3);
      chk("tmo_noenter", n_en - e0, 0);
      chk("tmo_fault_once", n_ft - f0, 1);
      chk("tmo_busy_clr", sen.busy, 1'b0);

      // asynchronous reset while in EN_AB
      base();
      drive(2'b10, 5); drive(2'b11, 5);
      chk("rst_pre_busy", sen.busy, 1'b1);
      #1 reset = 1'b1;
      sen.a = 1'b0;
      sen.b = 1'b1;
      #1;
      chk("arst_busy", sen.busy, 1'b0);
      chk("arst_enter", sen.enter, 1'b0);
      chk("arst_fault", sen.fault, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      drive(2'b01, 5);
      chk("arst_exb_busy", sen.busy, 1'b1);
      drive(2'b00, 5);
      chk("arst_noenter", n_en - e0, 0);
      chk("arst_noexit", n_ex - x0, 0);
      chk("arst_nofault", n_ft - f0, 0);
      chk("arst_idle", sen.busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
